dma_tx: RTL

- DMA transmit engine. It is the reader and sender end of the CPU's TYPE_4 SEND path.
- On a CPU send command it:
  - requests the shared RAM bus,
  - reads TX_BYTES consecutive bytes starting at DMA_TX_BUFFER_MSB (8'h04; MSB first, then LSB at 8'h05),
  - releases the bus,
  - streams the bytes, MSB first, to the serial transmitter over a valid/ready byte interface.
- Sits between the CPU, the RAM arbiter and the RS232 transmitter.

---
 rtl/dma_tx.sv | 101 ++++++++++
 1 files changed

// File: rtl/dma_tx.sv
// dma_tx: DMA transmit engine; snapshots TX_BYTES from RAM and streams them MSB first.
// Define DMA_TX_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module dma_tx #(
    parameter int RAM_AW = 8,
    parameter logic [RAM_AW-1:0] TX_BASE = 8'h04,
    parameter int TX_BYTES = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Send_comm,
    output logic              Dma_tx_busy,
    output logic              Dma_tx_done,
    output logic              Dma_bus_req,
    input  logic              Dma_bus_gnt,
    output logic [RAM_AW-1:0] Ram_addr,
    output logic              Ram_cs,
    output logic              Ram_oe,
    input  logic [7:0]        Ram_data,
    output logic [7:0]        Tx_data,
    output logic              Tx_valid,
    input  logic              Tx_ready
);
`ifdef DMA_TX_CHECKSUM_EN
    localparam int NB = TX_BYTES + 1;
`else
    localparam int NB = TX_BYTES;
`endif
    localparam int W = 8 * NB;
    localparam logic [2:0] LAST_RD = 3'(TX_BYTES - 1);
    localparam logic [2:0] LAST_TX = 3'(NB - 1);

    typedef enum logic [2:0] {IDLE, REQ, READ, LATCH, SEND, DONE} state_t;
    state_t state, next;
    logic [2:0] cnt;
    logic [W-1:0] sh;
    logic [W-1:0] sh_in;
    logic xfer;

    assign xfer = Tx_valid && Tx_ready;
    // Bytes are shifted in as read and shifted out from the top as sent.
    assign Tx_data = sh[W-1 -: 8];

`ifdef DMA_TX_CHECKSUM_EN
    logic [7:0] chk, chk_nx;
    assign chk_nx = (cnt == '0 ? 8'h00 : chk) ^ Ram_data;
    assign sh_in = cnt == LAST_RD ? W'({sh, Ram_data, chk_nx}) : W'({sh, Ram_data});
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) chk <= '0;
        else if (state == LATCH && Dma_bus_gnt) chk <= chk_nx;
`else
    assign sh_in = W'({sh, Ram_data});
`endif

    always_ff @(posedge Clk or posedge Rst)
        if (Rst) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = Send_comm ? REQ : IDLE;
            REQ:     next = Dma_bus_gnt ? READ : REQ;
            READ:    next = Dma_bus_gnt ? LATCH : REQ;
            LATCH:   next = !Dma_bus_gnt ? REQ : cnt == LAST_RD ? SEND : READ;
            SEND:    next = xfer && cnt == LAST_TX ? DONE : SEND;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        Dma_tx_busy = state != IDLE;
        Dma_tx_done = state == DONE;
        Dma_bus_req = state == REQ || state == READ || state == LATCH;
        Ram_cs = state == READ && Dma_bus_gnt;
        Ram_oe = Ram_cs;
        Ram_addr = Ram_cs ? TX_BASE + RAM_AW'(cnt) : '0;
    end

    // A grant loss restarts the whole read so the snapshot stays consistent.
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            cnt <= '0;
            sh <= '0;
            Tx_valid <= 1'b0;
        end else begin
            Tx_valid <= next == SEND;
            case (state)
                IDLE: cnt <= '0;
                READ: cnt <= Dma_bus_gnt ? cnt : '0;
                LATCH: begin
                    cnt <= !Dma_bus_gnt || cnt == LAST_RD ? '0 : cnt + 3'd1;
                    if (Dma_bus_gnt) sh <= sh_in;
                end
                SEND: if (xfer) begin
                    cnt <= cnt + 3'd1;
                    sh <= sh << 8;
                end
                default: ;
            endcase
        end
endmodule
